// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor: one sum/carry cell reused over WIDTH cycles.
// Optional signed-overflow output is built when SERIAL_OVF_EN is defined.
module serial_add_sub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
`ifdef SERIAL_OVF_EN
  output logic             Overflow,
`endif
  output logic             Cout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] part_r;
  logic [WIDTH-1:0] sum_r;
  logic [CW-1:0]    cnt_r;
  logic             c_r;
  logic             cout_r;
  logic             s_s;
  logic             c_nxt_s;
  logic             last_s;
`ifdef SERIAL_OVF_EN
  logic             ovf_r;
`endif

  // Shared full-adder cell on the current LSBs
  assign s_s     = a_r[0] ^ b_r[0] ^ c_r;
  assign c_nxt_s = (a_r[0] & b_r[0]) | (c_r & (a_r[0] ^ b_r[0]));
  assign last_s  = (cnt_r == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Operand load, serial shift and result capture on the final bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= {WIDTH{1'b0}};
      b_r    <= {WIDTH{1'b0}};
      part_r <= {WIDTH{1'b0}};
      sum_r  <= {WIDTH{1'b0}};
      cnt_r  <= {CW{1'b0}};
      c_r    <= 1'b0;
      cout_r <= 1'b0;
`ifdef SERIAL_OVF_EN
      ovf_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            a_r   <= A;
            b_r   <= Sub ? ~B : B;
            c_r   <= Sub;
            cnt_r <= {CW{1'b0}};
          end
        end
        ST_SHIFT: begin
          a_r    <= {1'b0, a_r[WIDTH-1:1]};
          b_r    <= {1'b0, b_r[WIDTH-1:1]};
          part_r <= {s_s, part_r[WIDTH-1:1]};
          c_r    <= c_nxt_s;
          cnt_r  <= cnt_r + CW'(1);
          if (last_s) begin
            sum_r  <= {s_s, part_r[WIDTH-1:1]};
            cout_r <= c_nxt_s;
`ifdef SERIAL_OVF_EN
            // c_r here is the carry into the MSB
            ovf_r  <= c_r ^ c_nxt_s;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state_r != ST_IDLE);
  assign done = (state_r == ST_DONE);
  assign Sum  = sum_r;
  assign Cout = cout_r;
`ifdef SERIAL_OVF_EN
  assign Overflow = ovf_r;
`endif

endmodule
